// File: rtl/cond_pkg.sv
// -----------------------------------------------------------------------------
// cond_pkg
// Shared types and constants for the condition / flag logic.
//   cond_e   : instruction condition field encodings (EQ..AL, NV)
//   flags_t  : architectural flag vector {N,Z,C,V}
//   FLAG_*   : bit positions of each flag inside flags_t / ALUFlags
// -----------------------------------------------------------------------------
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'd0,
      NE = 4'd1,
      CS = 4'd2,
      CC = 4'd3,
      MI = 4'd4,
      PL = 4'd5,
      VS = 4'd6,
      VC = 4'd7,
      HI = 4'd8,
      LS = 4'd9,
      GE = 4'd10,
      LT = 4'd11,
      GT = 4'd12,
      LE = 4'd13,
      AL = 4'd14,
      NV = 4'd15
   } cond_e;

   typedef logic [3:0] flags_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// -----------------------------------------------------------------------------
// cond_check
// Purely combinational evaluation of a condition field against a flag vector.
// Ports:
//   Cond   (in)  condition field
//   Flags  (in)  {N,Z,C,V} to evaluate against
//   CondEx (out) 1 when the condition passes
// NV (15) is treated as always-pass, same as AL.
// -----------------------------------------------------------------------------
module cond_check
   import cond_pkg::*;
(
   input  cond_e  Cond,
   input  flags_t Flags,
   output logic   CondEx
);

   logic w_n;
   logic w_z;
   logic w_c;
   logic w_v;
   logic w_ge;

   assign w_n  = Flags[FLAG_N];
   assign w_z  = Flags[FLAG_Z];
   assign w_c  = Flags[FLAG_C];
   assign w_v  = Flags[FLAG_V];
   assign w_ge = (w_n == w_v);

   // Condition table; signed comparisons derive from N==V.
   always_comb begin
      CondEx = 1'b1;
      case (Cond)
         EQ:      CondEx = w_z;
         NE:      CondEx = ~w_z;
         CS:      CondEx = w_c;
         CC:      CondEx = ~w_c;
         MI:      CondEx = w_n;
         PL:      CondEx = ~w_n;
         VS:      CondEx = w_v;
         VC:      CondEx = ~w_v;
         HI:      CondEx = w_c & ~w_z;
         LS:      CondEx = ~w_c | w_z;
         GE:      CondEx = w_ge;
         LT:      CondEx = ~w_ge;
         GT:      CondEx = ~w_z & w_ge;
         LE:      CondEx = w_z | ~w_ge;
         default: CondEx = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// -----------------------------------------------------------------------------
// cond_logic
// Holds the architectural flags, evaluates the instruction condition, gates
// the datapath write enables and provides a small LIFO shadow stack of flags
// for exception entry/return.
// Ports:
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   Cond              instruction condition field
//   ALUFlags          {N,Z,C,V} from the ALU this cycle
//   FlagW             [1] write N,Z  [0] write C,V
//   CondExLatch       capture condition result into CondEx
//   PCS, NextPC       conditional / unconditional PC write requests
//   RegW, MemW        register-file / memory write requests
//   FlagSave          push Flags onto the shadow stack
//   FlagRestore       pop the shadow stack into Flags
//   PCWrite, RegWrite, MemWrite   gated write enables
//   CondEx            registered condition result
//   Flags             architectural flags
//   SaveCount         shadow stack occupancy
//   SaveErr           one-cycle pulse after an illegal stack operation
// -----------------------------------------------------------------------------
module cond_logic
   import cond_pkg::*;
#(
   parameter int SAVE_DEPTH = 2
)(
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [3:0]                          Cond,
   input  logic [3:0]                          ALUFlags,
   input  logic [1:0]                          FlagW,
   input  logic                                CondExLatch,
   input  logic                                PCS,
   input  logic                                NextPC,
   input  logic                                RegW,
   input  logic                                MemW,
   input  logic                                FlagSave,
   input  logic                                FlagRestore,
   output logic                                PCWrite,
   output logic                                RegWrite,
   output logic                                MemWrite,
   output logic                                CondEx,
   output logic [3:0]                          Flags,
   output logic [$clog2(SAVE_DEPTH+1)-1:0]     SaveCount,
   output logic                                SaveErr
);

   localparam int CW = $clog2(SAVE_DEPTH + 1);
   // Index width is at least one bit so a depth-1 stack still has a valid
   // address; the array is sized to the full index range to keep selects
   // width-exact, and occupancy never lets the unused slots be touched.
   localparam int IW = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;

   flags_t          r_flags;
   logic            r_condEx;
   logic [CW-1:0]   r_count;
   logic            r_saveErr;
   flags_t          r_stack [2**IW];

   logic            w_condPass;
   logic            w_full;
   logic            w_empty;
   logic            w_both;
   logic            w_push;
   logic            w_pop;
   logic            w_err;
   logic [IW-1:0]   w_pushIdx;
   logic [IW-1:0]   w_topIdx;
   flags_t          w_flagsNext;

   // Condition is always evaluated on the registered flags, never on the
   // ALU flags of the current cycle.
   cond_check u_condCheck (
      .Cond   (cond_e'(Cond)),
      .Flags  (r_flags),
      .CondEx (w_condPass)
   );

   assign w_full    = (r_count == CW'(SAVE_DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_both    = FlagSave & FlagRestore;
   assign w_push    = FlagSave & ~FlagRestore & ~w_full;
   assign w_pop     = FlagRestore & ~FlagSave & ~w_empty;
   assign w_err     = w_both
                    | (FlagSave & ~FlagRestore & w_full)
                    | (FlagRestore & ~FlagSave & w_empty);
   assign w_pushIdx = IW'(r_count);
   assign w_topIdx  = IW'(r_count - CW'(1));

   // Next flags: a successful pop wins over any ALU write; otherwise the two
   // halves update independently, each qualified by the registered CondEx.
   always_comb begin
      w_flagsNext = r_flags;
      if (w_pop) begin
         w_flagsNext = r_stack[w_topIdx];
      end else begin
         if (FlagW[1] & r_condEx) begin
            w_flagsNext[FLAG_N] = ALUFlags[FLAG_N];
            w_flagsNext[FLAG_Z] = ALUFlags[FLAG_Z];
         end
         if (FlagW[0] & r_condEx) begin
            w_flagsNext[FLAG_C] = ALUFlags[FLAG_C];
            w_flagsNext[FLAG_V] = ALUFlags[FLAG_V];
         end
      end
   end

   // Architectural state: flags, latched condition, stack occupancy and the
   // error pulse. Reset discards any in-flight stack operation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_flags   <= '0;
         r_condEx  <= 1'b0;
         r_count   <= '0;
         r_saveErr <= 1'b0;
      end else begin
         r_flags   <= w_flagsNext;
         r_saveErr <= w_err;
         if (CondExLatch) begin
            r_condEx <= w_condPass;
         end
         if (w_push) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // Stack storage needs no reset: occupancy alone defines what is valid.
   // A push stores the pre-edge flags, so a same-cycle ALU write is not seen.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_stack[w_pushIdx] <= r_flags;
      end
   end

   assign PCWrite   = (PCS & r_condEx) | NextPC;
   assign RegWrite  = RegW & r_condEx;
   assign MemWrite  = MemW & r_condEx;
   assign CondEx    = r_condEx;
   assign Flags     = r_flags;
   assign SaveCount = r_count;
   assign SaveErr   = r_saveErr;

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Consumer end of the ALU flag interface: takes the 4-bit `ALUFlags` bus {N,Z,C,V} and holds the architectural flags register.
- Evaluates the 4-bit instruction condition field against the registered flags.
- Gates the PC, register-file and memory write enables for the multicycle datapath.
- Adds a small LIFO shadow stack so flags can be saved on exception entry and restored on return.

Parameters:
- SAVE_DEPTH, 2, number of entries in the flag shadow stack (1..8).

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- Cond  input  4  instruction condition field
- ALUFlags  input  4  {N,Z,C,V} from the ALU, same cycle
- FlagW  input  2  [1]: write N,Z; [0]: write C,V
- CondExLatch  input  1  capture condition result (decode state)
- PCS  input  1  instruction writes PC
- NextPC  input  1  unconditional PC increment
- RegW  input  1  instruction writes register file
- MemW  input  1  instruction writes memory
- FlagSave  input  1  push current Flags onto shadow stack
- FlagRestore  input  1  pop shadow stack into Flags
- PCWrite  output  1  gated PC write
- RegWrite  output  1  gated register write
- MemWrite  output  1  gated memory write
- CondEx  output  1  registered condition-passed
- Flags  output  4  architectural {N,Z,C,V}
- SaveCount  output  $clog2(SAVE_DEPTH+1)  stack occupancy
- SaveErr  output  1  one-cycle pulse on illegal stack operation

Behaviour:
- Reset (async, reset_n=0):
  - Flags=0, CondEx=0, SaveCount=0, SaveErr=0, stack contents don't-care.
  - Hence RegWrite=MemWrite=0 and PCWrite=NextPC.
- Condition check is combinational on the registered Flags, never on ALUFlags:
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C
  - 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V
  - 8 HI C&~Z; 9 LS ~C|Z
  - 10 GE N==V; 11 LT N!=V
  - 12 GT ~Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 treated as 1
- CondEx register: loads the check result on a cycle with CondExLatch=1, otherwise holds. Visible one cycle after the latch edge.
- Output gating (combinational from the CondEx register):
  - PCWrite = (PCS & CondEx) | NextPC
  - RegWrite = RegW & CondEx
  - MemWrite = MemW & CondEx
- Flag update on the clock edge, when no restore is occurring:
  - Flags[3:2] <= ALUFlags[3:2] if FlagW[1] & CondEx.
  - Flags[1:0] <= ALUFlags[1:0] if FlagW[0] & CondEx.
  - The two halves are independent.
- Save (FlagSave=1, FlagRestore=0):
  - Not full: push pre-edge Flags, SaveCount+1.
  - Same-cycle ALU flag write still occurs; the stack gets the old value.
- Restore (FlagRestore=1, FlagSave=0):
  - Not empty: Flags <= top entry, SaveCount-1.
  - Restore overrides any same-cycle FlagW write.
- Error cases; each pulses SaveErr for one cycle:
  - Push when SaveCount==SAVE_DEPTH: dropped, stack unchanged, normal flag write proceeds.
  - Pop when empty: Flags unchanged by the stack, FlagW write proceeds normally.
  - FlagSave & FlagRestore together: neither stack operation occurs, FlagW write proceeds.
- Stack is strict LIFO; no wrap-around.
- Reset mid-sequence: clears the stack and Flags immediately, with no completion of the in-flight operation.

Decomposition:
- Package cond_pkg:
  - cond_e enum (EQ..AL, NV=15).
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - flags_t typedef (logic [3:0]).
- Sub-module cond_check: purely combinational, (cond_e Cond, flags_t Flags) -> CondEx. Reused by later pipelined control.
- Shadow stack stays inline.

Test Plan:
- Reset, then Cond=14, CondExLatch=1, RegW=1, MemW=1 -> next cycle CondEx=1, RegWrite=1, MemWrite=1.
  - During reset, NextPC=1 -> PCWrite=1 and RegWrite=0.
- ALUFlags=4'b0100, FlagW=2'b11, CondEx=1 -> Flags=4'b0100.
  - Then Cond=0 (EQ) latched -> CondEx=1.
  - Cond=1 (NE) latched -> CondEx=0, RegWrite=0 with RegW=1.
- CondEx=0, FlagW=2'b11, ALUFlags=4'b1111 -> Flags unchanged.
  - CondEx=1, FlagW=2'b01, ALUFlags=4'b1010 from Flags=4'b0100 -> Flags=4'b0110.
- Sweep all 16 Cond values over all 16 Flags values -> CondEx matches the table; specifically:
  - Flags N=1, V=0, Z=0: GT=0, LT=1.
  - Flags C=1, Z=0: HI=1.
- SAVE_DEPTH=2, Flags=A: save. Set Flags=B: save. Set Flags=C: save again -> SaveErr pulses, SaveCount stays 2.
  - Restore -> Flags=B; restore -> Flags=A; restore again -> SaveErr, Flags=A.
- Same cycle FlagRestore=1 with FlagW=2'b11 -> Flags=popped value.
  - FlagSave & FlagRestore together -> SaveErr, SaveCount unchanged.
  - reset_n pulsed low mid-stack -> SaveCount=0, Flags=0 asynchronously.
